// File: rtl/aoi222_gate_unit_pkg.sv
// Shared definitions for the AOI222 gate unit: term count, width defaults
// and the per-lane term-hit vector type.
package aoi_pkg;

   // Number of AND pairs feeding the inverting OR (A, B, C)
   localparam int AOI_TERMS = 3;

   // Default and legal lane counts for the vector wrapper
   localparam int AOI_WIDTH_DEFAULT = 1;
   localparam int AOI_WIDTH_MIN     = 1;
   localparam int AOI_WIDTH_MAX     = 64;

   // Per-lane term hits, packed as {C-hit, B-hit, A-hit}
   typedef logic [AOI_TERMS-1:0] term_hit_t;

endpackage

// File: rtl/aoi222_gate_unit_lane.sv
// Single-bit AOI222 cell: three AND pairs, ORed and inverted.
// Also exposes the individual pair hits so the wrapper can register them.
module aoi222_lane
   import aoi_pkg::*;
(
   input  logic      a1,
   input  logic      a2,
   input  logic      b1,
   input  logic      b2,
   input  logic      c1,
   input  logic      c2,
   output logic      zn,
   output term_hit_t hit
);

   // Pair hits are formed first; the output is low whenever any pair fires
   always_comb begin
      hit = {c1 & c2, b1 & b2, a1 & a2};
      zn  = ~(hit[0] | hit[1] | hit[2]);
   end

endmodule

// File: rtl/aoi222_gate_unit.sv
// WIDTH-lane bitwise AOI222 block with a purely combinational result and an
// enable-qualified registered copy (result, term hits and a sticky valid).
module aoi222_gate_unit
   import aoi_pkg::*;
#(
   parameter int WIDTH = AOI_WIDTH_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   input  logic [WIDTH-1:0]           A1,
   input  logic [WIDTH-1:0]           A2,
   input  logic [WIDTH-1:0]           B1,
   input  logic [WIDTH-1:0]           B2,
   input  logic [WIDTH-1:0]           C1,
   input  logic [WIDTH-1:0]           C2,
   output logic [WIDTH-1:0]           ZN,
   output logic [WIDTH-1:0]           zn_q,
   output logic [AOI_TERMS*WIDTH-1:0] term_q,
   output logic                       valid_q
);

   term_hit_t                  lane_hit [WIDTH];
   logic [AOI_TERMS*WIDTH-1:0] term_comb;

   // One independent cell per lane; no cross-lane logic exists anywhere
   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      aoi222_lane u_lane (
         .a1  (A1[i]),
         .a2  (A2[i]),
         .b1  (B1[i]),
         .b2  (B2[i]),
         .c1  (C1[i]),
         .c2  (C2[i]),
         .zn  (ZN[i]),
         .hit (lane_hit[i])
      );
      assign term_comb[AOI_TERMS*i +: AOI_TERMS] = lane_hit[i];
   end

   // Capture result and term hits on enabled edges; reset to the all-zero-input
   // result (all ones) with no hits, and valid stays high once set until reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zn_q    <= '1;
         term_q  <= '0;
         valid_q <= 1'b0;
      end else if (en) begin
         zn_q    <= ZN;
         term_q  <= term_comb;
         valid_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_aoi222_gate_unit.sv
// Self-checking bench for aoi222_gate_unit: a single-lane and a four-lane
// instance share clock, reset and enable; results are compared against a
// pair-counting reference model and hand-derived constants.
module tb_aoi222_gate_unit;

   logic clk = 1'b0;
   logic rst_n;
   logic en;

   // Single-lane instance signals
   logic [0:0]  a1_s, a2_s, b1_s, b2_s, c1_s, c2_s;
   logic [0:0]  zn_s, zn_q_s;
   logic [2:0]  term_q_s;
   logic        valid_q_s;

   // Four-lane instance signals
   logic [3:0]  a1_w, a2_w, b1_w, b2_w, c1_w, c2_w;
   logic [3:0]  zn_w, zn_q_w;
   logic [11:0] term_q_w;
   logic        valid_q_w;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic [5:0] in;
      logic       zn;
   } vec_t;

   vec_t vecs [8];

   // Reference model state for the registered paths
   logic [0:0]  exp_zn_q_s;
   logic [2:0]  exp_term_q_s;
   logic        exp_valid_s;
   logic [3:0]  exp_zn_q_w;
   logic [11:0] exp_term_q_w;
   logic        exp_valid_w;

   always #5 clk = ~clk;

   aoi222_gate_unit #(.WIDTH(1)) u_dut_s (
      .clk(clk), .rst_n(rst_n), .en(en),
      .A1(a1_s), .A2(a2_s), .B1(b1_s), .B2(b2_s), .C1(c1_s), .C2(c2_s),
      .ZN(zn_s), .zn_q(zn_q_s), .term_q(term_q_s), .valid_q(valid_q_s)
   );

   aoi222_gate_unit #(.WIDTH(4)) u_dut_w (
      .clk(clk), .rst_n(rst_n), .en(en),
      .A1(a1_w), .A2(a2_w), .B1(b1_w), .B2(b2_w), .C1(c1_w), .C2(c2_w),
      .ZN(zn_w), .zn_q(zn_q_w), .term_q(term_q_w), .valid_q(valid_q_w)
   );

   // Term hits of one lane: a pair hits when its two bits sum to two
   function automatic logic [2:0] model_hits(input logic [5:0] v);
      int sa, sb, sc;
      sa = int'(v[5]) + int'(v[4]);
      sb = int'(v[3]) + int'(v[2]);
      sc = int'(v[1]) + int'(v[0]);
      return {sc == 2, sb == 2, sa == 2};
   endfunction

   // Lane output is one only when no pair hits at all
   function automatic logic model_zn(input logic [5:0] v);
      return (model_hits(v) == 3'b000);
   endfunction

   // Extract the 6-bit {A1,A2,B1,B2,C1,C2} view of lane i of a wide vector
   function automatic logic [5:0] lane_bits(input logic [23:0] v4, input int i);
      return {v4[20+i], v4[16+i], v4[12+i], v4[8+i], v4[4+i], v4[i]};
   endfunction

   function automatic logic [3:0] model_zn_w(input logic [23:0] v4);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = model_zn(lane_bits(v4, i));
      return r;
   endfunction

   function automatic logic [11:0] model_term_w(input logic [23:0] v4);
      logic [11:0] r;
      for (int i = 0; i < 4; i++) r[3*i +: 3] = model_hits(lane_bits(v4, i));
      return r;
   endfunction

   task automatic applyStimulus(input logic [5:0] v1, input logic [23:0] v4);
      {a1_s, a2_s, b1_s, b2_s, c1_s, c2_s} = v1;
      {a1_w, a2_w, b1_w, b2_w, c1_w, c2_w} = v4;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkRegsModel(input string tag);
      checkOutput({tag, " zn_q_s"},    64'(zn_q_s),    64'(exp_zn_q_s));
      checkOutput({tag, " term_q_s"},  64'(term_q_s),  64'(exp_term_q_s));
      checkOutput({tag, " valid_q_s"}, 64'(valid_q_s), 64'(exp_valid_s));
      checkOutput({tag, " zn_q_w"},    64'(zn_q_w),    64'(exp_zn_q_w));
      checkOutput({tag, " term_q_w"},  64'(term_q_w),  64'(exp_term_q_w));
      checkOutput({tag, " valid_q_w"}, 64'(valid_q_w), 64'(exp_valid_w));
   endtask

   initial begin
      int ones;
      logic [5:0]  r1;
      logic [23:0] r4;

      vecs[0] = '{6'b000000, 1'b1};
      vecs[1] = '{6'b000001, 1'b1};
      vecs[2] = '{6'b010101, 1'b1};
      vecs[3] = '{6'b101010, 1'b1};
      vecs[4] = '{6'b000011, 1'b0};
      vecs[5] = '{6'b001100, 1'b0};
      vecs[6] = '{6'b110000, 1'b0};
      vecs[7] = '{6'b111111, 1'b0};

      // Reset held with all-ones inputs and enable high across edges
      rst_n = 1'b0;
      en    = 1'b1;
      applyStimulus(6'b111111, 24'hFFFFFF);
      repeat (3) @(negedge clk);
      checkOutput("reset zn_q_s",    64'(zn_q_s),    64'h1);
      checkOutput("reset term_q_s",  64'(term_q_s),  64'h0);
      checkOutput("reset valid_q_s", 64'(valid_q_s), 64'h0);
      checkOutput("reset ZN_s",      64'(zn_s),      64'h0);
      checkOutput("reset zn_q_w",    64'(zn_q_w),    64'hF);
      checkOutput("reset term_q_w",  64'(term_q_w),  64'h0);
      checkOutput("reset valid_q_w", 64'(valid_q_w), 64'h0);

      // Release reset with enable low; registers must hold reset values
      rst_n = 1'b1;
      en    = 1'b0;

      // Table of required single-lane results
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].in, 24'h0);
         #10;
         checkOutput($sformatf("table ZN %b", vecs[i].in), 64'(zn_s), 64'(vecs[i].zn));
      end

      // Exhaustive single-lane sweep against the model and the ones count
      ones = 0;
      for (int v = 0; v < 64; v++) begin
         applyStimulus(6'(v), 24'h0);
         #10;
         checkOutput($sformatf("sweep ZN %b", 6'(v)), 64'(zn_s), 64'(model_zn(6'(v))));
         if (zn_s === 1'b1) ones++;
      end
      checkOutput("sweep ones count", 64'(ones), 64'd27);
      checkOutput("hold zn_q_s",    64'(zn_q_s),    64'h1);
      checkOutput("hold valid_q_s", 64'(valid_q_s), 64'h0);

      // Registered capture of a B-term hit
      @(negedge clk);
      applyStimulus(6'b001100, 24'h0);
      en = 1'b1;
      @(negedge clk);
      checkOutput("cap zn_q_s",    64'(zn_q_s),    64'h0);
      checkOutput("cap term_q_s",  64'(term_q_s),  64'b010);
      checkOutput("cap valid_q_s", 64'(valid_q_s), 64'h1);
      en = 1'b0;
      applyStimulus(6'b000000, 24'h0);
      #1;
      checkOutput("en0 ZN_s",   64'(zn_s),   64'h1);
      checkOutput("en0 zn_q_s", 64'(zn_q_s), 64'h0);
      @(negedge clk);
      checkOutput("en0 hold zn_q_s",   64'(zn_q_s),   64'h0);
      checkOutput("en0 hold term_q_s", 64'(term_q_s), 64'b010);

      // Asynchronous reset between edges, then held while enable is high
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async zn_q_s",    64'(zn_q_s),    64'h1);
      checkOutput("async valid_q_s", 64'(valid_q_s), 64'h0);
      checkOutput("async term_q_s",  64'(term_q_s),  64'h0);
      @(negedge clk);
      en = 1'b1;
      applyStimulus(6'b111111, 24'hFFFFFF);
      repeat (2) @(negedge clk);
      checkOutput("rst win zn_q_s",    64'(zn_q_s),    64'h1);
      checkOutput("rst win valid_q_s", 64'(valid_q_s), 64'h0);
      checkOutput("rst win ZN_s",      64'(zn_s),      64'h0);
      rst_n = 1'b1;

      // All three terms hitting at once
      @(negedge clk);
      checkOutput("multi ZN_s",      64'(zn_s),      64'h0);
      checkOutput("multi term_q_s",  64'(term_q_s),  64'b111);
      checkOutput("multi zn_q_s",    64'(zn_q_s),    64'h0);
      checkOutput("multi valid_q_s", 64'(valid_q_s), 64'h1);

      // Four-lane directed vector
      applyStimulus(6'b000000, {4'b1111, 4'b0101, 4'b1000, 4'b1000, 4'b0000, 4'b0000});
      #1;
      checkOutput("lanes ZN_w", 64'(zn_w), 64'b0010);
      @(negedge clk);
      checkOutput("lanes zn_q_w",   64'(zn_q_w),   64'b0010);
      checkOutput("lanes term_q_w", 64'(term_q_w), 64'b010_001_000_001);

      // Fresh reset, then randomized traffic checked against the model
      rst_n = 1'b0;
      en    = 1'b0;
      @(negedge clk);
      rst_n        = 1'b1;
      exp_zn_q_s   = '1;
      exp_term_q_s = '0;
      exp_valid_s  = 1'b0;
      exp_zn_q_w   = '1;
      exp_term_q_w = '0;
      exp_valid_w  = 1'b0;
      checkRegsModel("post reset");
      for (int n = 0; n < 150; n++) begin
         r1 = 6'($urandom);
         r4 = 24'($urandom);
         applyStimulus(r1, r4);
         en = ($urandom_range(0, 2) != 0);
         #1;
         checkOutput("rand ZN_s", 64'(zn_s), 64'(model_zn(r1)));
         checkOutput("rand ZN_w", 64'(zn_w), 64'(model_zn_w(r4)));
         if (en) begin
            exp_zn_q_s   = model_zn(r1);
            exp_term_q_s = model_hits(r1);
            exp_valid_s  = 1'b1;
            exp_zn_q_w   = model_zn_w(r4);
            exp_term_q_w = model_term_w(r4);
            exp_valid_w  = 1'b1;
         end
         @(negedge clk);
         checkRegsModel("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
